// File: rtl/motor_duty_ramp.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : motor_duty_ramp
// Frame-aligned period/duty command stage for a PWM generator: clamps the
// target duty, slews toward it, and brakes immediately. Slew ramping is built
// only with MOTOR_DUTY_RAMP_EN defined; otherwise duty jumps at the boundary.
// Rev    : 1.0
//==============================================================================
module motor_duty_ramp #(
  parameter int             N          = 32,
  parameter logic [N-1:0]   PERIOD_RST = N'(999)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [N-1:0] i_cmd_period,
  input  logic [N-1:0] i_cmd_duty,
  input  logic [N-1:0] i_ramp_step,
  input  logic [15:0]  i_ramp_div,
  input  logic         i_brake,
  output logic [N-1:0] o_period,
  output logic [N-1:0] o_duty,
  output logic         o_frame_tick,
  output logic         o_at_target
);

  localparam logic [1:0]   c_IDLE  = 2'd0;
  localparam logic [1:0]   c_BRAKE = 2'd2;
  localparam logic [N-1:0] c_ONES  = '1;

  logic [N-1:0] r_fc;
  logic [N-1:0] r_period;
  logic [N-1:0] r_duty;
  logic [N-1:0] r_target;
  logic [N-1:0] r_pend_period;
  logic [N-1:0] r_pend_duty;
  logic         r_pend_vld;
  logic         r_at_target;
  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;

  logic         w_bnd;
  logic         w_accept;
  logic         w_apply;
  logic [N-1:0] w_cap;
  logic [N-1:0] w_new_tgt;
  logic [N-1:0] w_tgt;
  logic [N-1:0] w_duty_bnd;
  logic [N-1:0] w_period_nxt;
  logic [N-1:0] w_duty_nxt;
  logic [N-1:0] w_target_nxt;
  logic         w_pend_vld_nxt;

  assign w_bnd     = (r_fc >= r_period);
  assign w_accept  = i_cmd_valid & o_cmd_ready;
  assign w_apply   = w_bnd & r_pend_vld;
  // An all-ones period has no representable period+1, so the cap saturates.
  assign w_cap     = (r_pend_period == c_ONES) ? c_ONES : r_pend_period + N'(1);
  assign w_new_tgt = (r_pend_duty < w_cap) ? r_pend_duty : w_cap;
  assign w_tgt     = w_apply ? w_new_tgt : r_target;

`ifdef MOTOR_DUTY_RAMP_EN
  localparam logic [1:0] c_RAMP = 2'd1;

  logic [15:0]  r_dv;
  logic [15:0]  w_dv_nxt;
  logic [N-1:0] w_base;
  logic [N-1:0] w_step;
  logic [N-1:0] w_mv;
  logic [N-1:0] w_stepped;
  logic [N:0]   w_gap;
  logic         w_up;
  logic         w_dv_hit;

  // A shrinking period pulls the applied duty down on the same boundary.
  assign w_base    = (w_apply && (r_duty > w_cap)) ? w_cap : r_duty;
  assign w_step    = (i_ramp_step == '0) ? N'(1) : i_ramp_step;
  assign w_up      = (w_tgt > w_base);
  assign w_gap     = w_up ? ({1'b0, w_tgt} - {1'b0, w_base})
                          : ({1'b0, w_base} - {1'b0, w_tgt});
  assign w_mv      = (w_gap > {1'b0, w_step}) ? w_step : w_gap[N-1:0];
  assign w_stepped = w_up ? (w_base + w_mv) : (w_base - w_mv);
  assign w_dv_hit  = (r_dv == i_ramp_div);
  assign w_duty_bnd = ((r_state == c_RAMP) && w_dv_hit) ? w_stepped : w_base;
`else
  logic w_unused_ramp;
  assign w_unused_ramp = ^{i_ramp_step, i_ramp_div};
  assign w_duty_bnd    = w_tgt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_brake)                  w_state_nxt = c_BRAKE;
    else if (r_state == c_BRAKE)  w_state_nxt = c_IDLE;
`ifdef MOTOR_DUTY_RAMP_EN
    else if (w_bnd)               w_state_nxt = (w_duty_bnd == w_tgt) ? c_IDLE : c_RAMP;
`endif
  end

  always_comb begin
    w_period_nxt   = r_period;
    w_duty_nxt     = r_duty;
    w_target_nxt   = r_target;
    w_pend_vld_nxt = r_pend_vld;
`ifdef MOTOR_DUTY_RAMP_EN
    w_dv_nxt       = r_dv;
`endif
    if (i_brake) begin
      w_duty_nxt     = '0;
      w_target_nxt   = '0;
      w_pend_vld_nxt = 1'b0;
`ifdef MOTOR_DUTY_RAMP_EN
      w_dv_nxt       = '0;
`endif
    end else if (r_state != c_BRAKE) begin
      if (w_bnd) begin
        w_duty_nxt     = w_duty_bnd;
        w_target_nxt   = w_tgt;
        w_pend_vld_nxt = 1'b0;
        if (w_apply) w_period_nxt = r_pend_period;
`ifdef MOTOR_DUTY_RAMP_EN
        if (w_duty_bnd == w_tgt)    w_dv_nxt = '0;
        else if (r_state == c_RAMP) w_dv_nxt = w_dv_hit ? 16'd0 : r_dv + 16'd1;
`endif
      end
      // A command taken on the boundary cycle waits for the following one.
      if (w_accept) w_pend_vld_nxt = 1'b1;
    end
  end

  assign o_cmd_ready  = ~r_pend_vld & (r_state != c_BRAKE) & ~i_brake;
  assign o_frame_tick = w_bnd;
  assign o_period     = r_period;
  assign o_duty       = r_duty;
  assign o_at_target  = r_at_target;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fc          <= '0;
      r_period      <= PERIOD_RST;
      r_duty        <= '0;
      r_target      <= '0;
      r_pend_vld    <= 1'b0;
      r_pend_period <= '0;
      r_pend_duty   <= '0;
      r_at_target   <= 1'b1;
`ifdef MOTOR_DUTY_RAMP_EN
      r_dv          <= '0;
`endif
    end else begin
      r_fc        <= w_bnd ? '0 : r_fc + N'(1);
      r_period    <= w_period_nxt;
      r_duty      <= w_duty_nxt;
      r_target    <= w_target_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_at_target <= (w_duty_nxt == w_target_nxt);
      if (w_accept) begin
        r_pend_period <= i_cmd_period;
        r_pend_duty   <= i_cmd_duty;
      end
`ifdef MOTOR_DUTY_RAMP_EN
      r_dv        <= w_dv_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_duty_ramp.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : tb_motor_duty_ramp
// Self-checking bench: reference model compared every cycle, directed
// sequences, a vector table and randomized commands/brake/reset.
// Rev    : 1.0
//==============================================================================
module tb_motor_duty_ramp;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_cmd_valid = 1'b0;
  logic [N-1:0] i_cmd_period = '0;
  logic [N-1:0] i_cmd_duty = '0;
  logic [N-1:0] i_ramp_step = '0;
  logic [15:0]  i_ramp_div = '0;
  logic         i_brake = 1'b0;
  logic         o_cmd_ready;
  logic [N-1:0] o_period;
  logic [N-1:0] o_duty;
  logic         o_frame_tick;
  logic         o_at_target;

  motor_duty_ramp #(.N(N), .PERIOD_RST(32'd999)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_period(i_cmd_period), .i_cmd_duty(i_cmd_duty),
    .i_ramp_step(i_ramp_step), .i_ramp_div(i_ramp_div), .i_brake(i_brake),
    .o_period(o_period), .o_duty(o_duty),
    .o_frame_tick(o_frame_tick), .o_at_target(o_at_target)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned lmin(input longint unsigned a, input longint unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: frame counter, pending command, clamped target, slew.
  bit [31:0] m_fc, m_period, m_duty, m_target, m_pp, m_pd;
  bit        m_pend, m_brk, m_at;
  bit [15:0] m_dv;

  always @(posedge clk) begin : ref_model
    longint unsigned per, tgt, d, cap;
    bit bnd, rdy;
`ifdef MOTOR_DUTY_RAMP_EN
    longint unsigned stp, gap;
    bit ramping;
    bit [15:0] dv;
`endif
    if (!rst) begin
      m_fc <= 0; m_period <= 999; m_duty <= 0; m_target <= 0; m_dv <= 0;
      m_pend <= 0; m_brk <= 0; m_at <= 1; m_pp <= 0; m_pd <= 0;
    end else begin
      bnd = (m_fc >= m_period);
      m_fc <= bnd ? 32'd0 : m_fc + 32'd1;
      rdy = !m_pend && !m_brk && !i_brake;
      if (i_brake) begin
        m_brk <= 1; m_duty <= 0; m_target <= 0; m_pend <= 0; m_dv <= 0; m_at <= 1;
      end else if (m_brk) begin
        m_brk <= 0;
      end else begin
        per = m_period; tgt = m_target; d = m_duty;
`ifdef MOTOR_DUTY_RAMP_EN
        ramping = (m_duty != m_target);
        dv = m_dv;
`endif
        if (bnd) begin
          if (m_pend) begin
            per = m_pp;
            cap = (m_pp == 32'hFFFF_FFFF) ? 64'(m_pp) : 64'(m_pp) + 1;
            tgt = lmin(m_pd, cap);
            d   = lmin(d, cap);
          end
`ifdef MOTOR_DUTY_RAMP_EN
          if (ramping && d != tgt) begin
            if (dv == i_ramp_div) begin
              stp = (i_ramp_step == 0) ? 1 : 64'(i_ramp_step);
              gap = (tgt > d) ? tgt - d : d - tgt;
              if (tgt > d) d = d + lmin(stp, gap);
              else         d = d - lmin(stp, gap);
              dv = 0;
            end else begin
              dv = dv + 16'd1;
            end
          end
          if (d == tgt) dv = 0;
`else
          d = tgt;
`endif
          m_pend <= 0;
        end
        if (i_cmd_valid && rdy) begin
          m_pend <= 1; m_pp <= i_cmd_period; m_pd <= i_cmd_duty;
        end
        m_period <= 32'(per); m_target <= 32'(tgt); m_duty <= 32'(d);
        m_at <= (d == tgt);
`ifdef MOTOR_DUTY_RAMP_EN
        m_dv <= dv;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_period", o_period, m_period);
      chk("m_duty", o_duty, m_duty);
      chk("m_frame_tick", o_frame_tick, (m_fc >= m_period));
      chk("m_at_target", o_at_target, m_at);
      chk("m_cmd_ready", o_cmd_ready, (!m_pend && !m_brk && !i_brake));
    end
  end

  task automatic next_bnd(output int cyc);
    bit seen;
    cyc = 0; seen = 0;
    while (!seen && cyc < 2000) begin
      @(negedge clk); cyc++; seen = o_frame_tick;
    end
    chk("bnd_seen", seen, 1);
    @(negedge clk); cyc++;
  endtask

  task automatic wait_at_target();
    int k = 0;
    int c;
    while (!o_at_target && k < 300) begin
      next_bnd(c); k++;
    end
    chk("at_target_reached", o_at_target, 1);
  endtask

  task automatic send(input logic [N-1:0] p, input logic [N-1:0] d);
    int k = 0;
    @(negedge clk);
    i_cmd_valid = 1; i_cmd_period = p; i_cmd_duty = d;
    while (!o_cmd_ready && k < 3000) begin
      @(negedge clk); k++;
    end
    chk("send_ready", o_cmd_ready, 1);
    @(posedge clk); #1;
    i_cmd_valid = 0;
  endtask

  typedef struct {
    logic [31:0] period;
    logic [31:0] duty;
    logic [31:0] step;
    logic [15:0] div;
    logic [31:0] exp_period;
    logic [31:0] exp_duty;
  } vec_t;

  vec_t tbl[6];
  int   exp3[9];

  initial begin
    int c;
    int k;
    tbl[0] = '{32'd4,  32'd3,  32'd0,          16'd0, 32'd4,  32'd3};
    tbl[1] = '{32'd20, 32'd21, 32'd7,          16'd2, 32'd20, 32'd21};
    tbl[2] = '{32'd20, 32'd30, 32'd7,          16'd0, 32'd20, 32'd21};
    tbl[3] = '{32'd0,  32'd5,  32'd1,          16'd0, 32'd0,  32'd1};
    tbl[4] = '{32'd7,  32'd0,  32'hFFFF_FFFF,  16'd1, 32'd7,  32'd0};
    tbl[5] = '{32'd15, 32'd9,  32'd3,          16'd3, 32'd15, 32'd9};
    exp3 = '{10, 10, 7, 7, 4, 4, 1, 1, 0};

    // Reset values
    @(negedge clk);
    chk_en = 1;
    chk("rst_period", o_period, 999);
    chk("rst_duty", o_duty, 0);
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_at_target", o_at_target, 1);
    chk("rst_frame_tick", o_frame_tick, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    // Ramp 0 -> 10 by 4 on every boundary
    i_ramp_step = 4; i_ramp_div = 0;
    send(9, 10);
    next_bnd(c);
    chk("s1_period", o_period, 9);
`ifdef MOTOR_DUTY_RAMP_EN
    chk("s1_duty_apply", o_duty, 0);
    next_bnd(c); chk("s1_duty_4", o_duty, 4); chk("s1_spacing", c, 10);
    next_bnd(c); chk("s1_duty_8", o_duty, 8); chk("s1_spacing", c, 10);
    next_bnd(c); chk("s1_duty_10", o_duty, 10);
`else
    chk("s1_duty_jump", o_duty, 10);
`endif
    chk("s1_at_target", o_at_target, 1);

    // Clamp of an oversize duty
    send(9, 50);
    next_bnd(c);
    chk("s2_duty_clamp", o_duty, 10);
    chk("s2_at_target", o_at_target, 1);
    next_bnd(c);
    chk("s2_duty_hold", o_duty, 10);

    // Ramp down by 3 every 2nd boundary
    i_ramp_step = 3; i_ramp_div = 1;
    send(9, 0);
    next_bnd(c);
`ifdef MOTOR_DUTY_RAMP_EN
    chk("s3_duty", o_duty, 32'(exp3[0]));
    for (int i = 1; i < 9; i++) begin
      next_bnd(c);
      chk("s3_duty", o_duty, 32'(exp3[i]));
    end
`else
    chk("s3_duty_jump", o_duty, 0);
`endif

    // Brake mid-ramp
    i_ramp_step = 2; i_ramp_div = 0;
    send(9, 10);
    next_bnd(c);
`ifdef MOTOR_DUTY_RAMP_EN
    repeat (3) next_bnd(c);
    chk("s4_duty_pre", o_duty, 6);
`else
    chk("s4_duty_pre", o_duty, 10);
`endif
    i_brake = 1;
    @(negedge clk);
    chk("s4_brake_duty", o_duty, 0);
    chk("s4_brake_ready", o_cmd_ready, 0);
    chk("s4_brake_at", o_at_target, 1);
    repeat (3) begin
      @(negedge clk);
      chk("s4_hold_ready", o_cmd_ready, 0);
    end
    i_brake = 0;
    @(negedge clk);
    chk("s4_release_ready", o_cmd_ready, 1);
    chk("s4_release_duty", o_duty, 0);
    next_bnd(c);
    chk("s4_duty_stays", o_duty, 0);

    // Accept exactly on a boundary cycle
    k = 0;
    while (!(o_frame_tick && o_cmd_ready) && k < 100) begin
      @(negedge clk); k++;
    end
    chk("s5_sync", o_frame_tick, 1);
    i_cmd_valid = 1; i_cmd_period = 5; i_cmd_duty = 3;
    @(posedge clk); #1;
    i_cmd_valid = 0;
    @(negedge clk);
    chk("s5_period_same", o_period, 9);
    chk("s5_duty_same", o_duty, 0);
    chk("s5_ready_low", o_cmd_ready, 0);
    repeat (3) begin
      @(negedge clk);
      chk("s5_ready_between", o_cmd_ready, 0);
    end
    next_bnd(c);
    chk("s5_period_new", o_period, 5);
`ifdef MOTOR_DUTY_RAMP_EN
    chk("s5_duty_apply", o_duty, 0);
`else
    chk("s5_duty_apply", o_duty, 3);
`endif
    chk("s5_ready_back", o_cmd_ready, 1);
    wait_at_target();
    chk("s5_duty_final", o_duty, 3);

    // Period decrease below the applied duty
    i_ramp_step = 100;
    send(99, 80);
    next_bnd(c);
    wait_at_target();
    chk("s6_period", o_period, 99);
    chk("s6_duty", o_duty, 80);
    send(49, 80);
    next_bnd(c);
    chk("s6_period_cut", o_period, 49);
    chk("s6_duty_cut", o_duty, 50);
    chk("s6_at_target", o_at_target, 1);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      i_ramp_step = tbl[i].step;
      i_ramp_div  = tbl[i].div;
      send(tbl[i].period, tbl[i].duty);
      next_bnd(c);
      wait_at_target();
      chk("tbl_period", o_period, tbl[i].exp_period);
      chk("tbl_duty", o_duty, tbl[i].exp_duty);
    end

    // Randomized commands, brake pulses and one mid-run reset
    i_ramp_div = 0;
    for (int i = 0; i < 200; i++) begin
      i_ramp_step = 32'($urandom_range(0, 4));
      send(32'($urandom_range(0, 15)), 32'($urandom_range(0, 20)));
      repeat ($urandom_range(0, 25)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        i_brake = 1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        i_brake = 0;
        i_ramp_div = 16'($urandom_range(0, 2));
        @(negedge clk);
      end
      if (i == 120) begin
        rst = 0;
        @(negedge clk);
        rst = 1;
      end
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/motor_duty_ramp.md
# motor_duty_ramp

Frame-synchronous duty/period command stage that sits directly upstream of the motor PWM generator and drives its `period` and `duty` inputs. It accepts target speed commands over a valid/ready handshake, clamps them to the legal duty range, and slews the applied duty toward the target by a programmable step every `ramp_div+1` PWM frames. It also provides an immediate brake. All updates land exactly on PWM frame boundaries, so the generator never sees a mid-frame change.

## Interface
- `N`, 32, datapath width; must equal the PWM generator width
- `PERIOD_RST`, 32'd999, `period` value after reset
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when both are high
- `cmd_period`  in  N  requested PWM period (frame = period+1 clocks)
- `cmd_duty`  in  N  requested target duty
- `ramp_step`  in  N  duty increment per ramp update; 0 treated as 1
- `ramp_div`  in  16  number of extra frames between ramp updates
- `brake`  in  1  level; forces duty to 0
- `period`  out  N  to PWM generator
- `duty`  out  N  to PWM generator
- `frame_tick`  out  1  high on the last clock of each frame
- `at_target`  out  1  applied duty equals clamped target

## Operation
- Internal frame counter `fc` mirrors the PWM generator:
  - `fc` increments while `fc < period`, otherwise it returns to 0.
  - Boundary condition `bnd = (fc >= period)`; `frame_tick = bnd`.
- Command capture:
  - `cmd_ready` is high when no command is pending.
  - On accept, `cmd_period`/`cmd_duty` are latched into a pending register and `cmd_ready` drops.
  - At the next `bnd`, `period` takes the pending period, the target takes the pending duty, and `cmd_ready` rises the following cycle.
  - If the accept happens on the `bnd` cycle itself, the command is applied at the following boundary, not at that one.
- Clamp: `target = min(cmd_duty, cmd_period+1)`.
  - Computed at N+1 bits.
  - If `cmd_period` is all-ones, the cap saturates to all-ones.
- States:
  - IDLE: `duty == target`.
  - RAMP: `duty != target`.
  - BRAKE: `brake == 1`.
- IDLE→RAMP at the boundary where a new target differs from `duty`.
- In RAMP, a boundary-count divider `dv` (16 bit) counts boundaries. At a boundary with `dv == ramp_div`:
  - `dv` resets to 0.
  - `duty` moves toward `target` by `min(step, |target-duty|)`, so it never overshoots.
  - Differences are computed at N+1 bits with no wrap.
- RAMP→IDLE when `duty` reaches `target`; `dv` is cleared on entry to IDLE.
- A new target accepted during RAMP replaces the old one at its boundary. Ramping continues from the current `duty`, and direction may reverse. `dv` is not cleared.
- A period decrease below the current `duty`: `duty` is clamped to `new period+1` on the same boundary.
- BRAKE:
  - Entered from any state on the cycle after `brake` is sampled high, without waiting for a boundary.
  - Sets `duty=0` and `target=0`, and discards any pending command.
  - `cmd_ready` is held 0 while `brake` is high.
  - On release, the block goes to IDLE, then `cmd_ready` rises.

## Timing
- Reset values:
  - `period=PERIOD_RST`, `duty=0`, `fc=0`, `dv=0`, state IDLE.
  - `cmd_ready=1`, `at_target=1`, `frame_tick=0`, pending cleared.
- Reset aligns `fc` with the PWM generator because both share `clk`/`rst`.
- `period` and `duty` are registered and change only on the clock edge that ends a `bnd` cycle, so the generator sees the new values at its count 0. BRAKE is the only exception.
- Command-to-apply latency: acceptance to the next boundary edge, at most `period+1` clocks.
- Brake latency: 1 clock, `brake` sampled to `duty==0`.
- `at_target` is registered and updates with `duty`/`target`.
- `rst` low mid-ramp returns the block to reset values on the next edge.

## Configuration
- `MOTOR_DUTY_RAMP_EN` defined: slew-limited ramping as described above.
- `MOTOR_DUTY_RAMP_EN` undefined:
  - RAMP is removed; `duty` jumps to the clamped target at the boundary.
  - `ramp_step` and `ramp_div` are ignored.
  - BRAKE and clamping are unchanged.

## Test plan
- Reset, `cmd_period=9`, `cmd_duty=10`, `ramp_step=4`, `ramp_div=0` → `duty` 4, 8, 10 at successive boundaries, 10 clocks apart; `at_target=1` after the third boundary.
- `cmd_duty=50`, `cmd_period=9` → target clamped to 10, `duty` never exceeds 10.
- At `duty=10`, send `cmd_duty=0`, `ramp_step=3`, `ramp_div=1` → `duty` 7, 4, 1, 0, updating every 2nd boundary.
- Assert `brake` mid-ramp at `duty=6` → `duty=0` next clock, `cmd_ready=0` while `brake` is high; after release, `cmd_ready=1` and `duty` stays 0.
- Accept a command exactly on a `bnd` cycle → `period`/`duty` unchanged at that boundary and applied at the next one; `cmd_ready` low in between.
- `period=99`, `duty=80`; command `cmd_period=49` → at the boundary `period=49` and `duty` clamped to 50.
